ysyx_ifu: RTL and testbench
===========================

// Module: ysyx_ifu
// PURPOSE
//  Multi-cycle instruction fetch stage feeding ysyx_IDU. Owns the PC and issues one fetch
//  at a time to instruction memory over a req/rsp handshake. Presents {inst, pc} downstream
//  with valid/ready. Accepts branch/jump redirects from EXU, squashing any stale fetch.
// PARAMETERS
//  RESET_PC   32'h8000_0000  PC value loaded on reset
//  XLEN       32             address/instruction width
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     asynchronous, active-low reset
//  mem_req_valid  out  1     fetch request valid
//  mem_req_ready  in   1     memory accepts request
//  mem_req_addr   out  XLEN  fetch address (word aligned)
//  mem_rsp_valid  in   1     response valid (always accepted; no rsp_ready)
//  mem_rsp_data   in   XLEN  fetched instruction
//  mem_rsp_err    in   1     access fault on this response
//  out_valid      out  1     {out_inst,out_pc} valid to IDU
//  out_ready      in   1     IDU/EXU consumes instruction
//  out_inst       out  XLEN  instruction word
//  out_pc         out  XLEN  PC of out_inst
//  out_err        out  1     fetch fault tag on out_inst
//  redirect       in   1     jump/branch taken (BrE|do_jump), 1-cycle pulse
//  redirect_addr  in   XLEN  redirect target
//  misalign       out  1     only with IFU_MISALIGN_CHK_EN; else tied 0
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, pc=RESET_PC, mem_req_valid=0, mem_req_addr=RESET_PC,
//    out_valid=0, out_inst=0, out_pc=RESET_PC, out_err=0, drop=0, misalign=0.
//  - FSM: IDLE -> REQ (first cycle after reset release).
//    REQ : mem_req_valid=1, addr=pc; on mem_req_ready -> WAIT. addr/valid stable until ready.
//    WAIT: on mem_rsp_valid: if drop -> REQ (drop<=0, data discarded);
//          else latch data/err/pc into out regs, out_valid<=1 -> HOLD.
//    HOLD: out_valid=1, outputs stable; on out_ready -> REQ, pc<=pc+4.
//  - Min latency: req accepted in cycle N, rsp in N+1 -> out_valid in N+2; 3 cycles/inst min.
//  - At most one outstanding fetch; a response in IDLE/REQ/HOLD is a protocol error (ignored).
//  - Redirect (priority over everything, any state but IDLE):
//    REQ : pc<=redirect_addr; in-flight req keeps old addr; set drop; complete handshake,
//          then WAIT discards response. If mem_req_ready same cycle -> WAIT with drop=1.
//    WAIT: pc<=redirect_addr, drop<=1. If mem_rsp_valid same cycle: discard rsp, -> REQ.
//    HOLD: out_valid<=0 next cycle, pc<=redirect_addr, -> REQ; simultaneous out_ready
//          still counts as consumed but pc takes redirect_addr, not pc+4.
//  - pc+4 wraps modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000), no flag.
//  - redirect_addr[1:0] ignored (forced 0) when macro undefined.
//  - mem_rsp_err: passed to out_err with the instruction; FSM flow unchanged.
//  - Reset asserted mid-fetch: all state cleared immediately; late response after release
//    lands in IDLE/REQ and is ignored.
// CONFIGURATION
//  IFU_MISALIGN_CHK_EN defined: redirect with redirect_addr[1:0]!=0 -> no fetch issued;
//    enter HOLD with out_valid=1, out_pc=redirect_addr, out_inst=0, misalign=1, out_err=0;
//    on out_ready -> IDLE-like stall (no fetch) until next redirect.
//  Undefined: low bits masked, misalign tied 0, no stall.
// TESTING
//  1 reset release, mem ready/rsp immediate -> req addr 0x80000000, 0x80000004, ...;
//    out_valid every 3rd cycle, out_pc matches.
//  2 mem_req_ready low 5 cycles -> valid/addr held stable 5 cycles; single handshake.
//  3 redirect to 0x80000100 while WAIT -> old rsp dropped (no out_valid), next req 0x80000100.
//  4 redirect in HOLD with out_ready=1 same cycle -> next req 0x80000200, not pc+4.
//  5 mem_rsp_err=1 on fetch at 0x80000008 -> out_err=1, out_pc=0x80000008; flow continues.
//  6 macro on, redirect 0x80000102 -> no req, out_valid=1, misalign=1, out_pc=0x80000102.

Source files
------------

// File: rtl/ysyx_ifu.sv
// Multi-cycle instruction fetch stage: owns the PC, issues one fetch at a time, presents {inst, pc} to IDU.
// Optional build macro IFU_MISALIGN_CHK_EN: misaligned redirect targets raise misalign instead of fetching.
module ysyx_ifu #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic            out_err,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            misalign,
    output logic [2:0]      dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; once valid is
    // raised, the payload is held stable until that edge. Responses have no ready.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_STALL = 3'd4
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] req_addr, req_addr_n;
    logic [XLEN-1:0] ra;
    logic            drop, drop_n;
    logic            load_out, load_mis;
    logic            mis_q, mis_n;

`ifdef IFU_MISALIGN_CHK_EN
    assign ra       = redirect_addr;
    assign misalign = mis_q;
`else
    assign ra       = {redirect_addr[XLEN-1:2], redirect_addr[1:0] & 2'b00};
    assign misalign = 1'b0;
`endif

    assign mem_req_valid = (state == ST_REQ);
    assign mem_req_addr  = req_addr;
    assign out_valid     = (state == ST_HOLD);
    assign dbg_state     = state;

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        drop_n   = drop;
        load_out = 1'b0;
        load_mis = 1'b0;
        case (state)
            ST_IDLE: state_n = ST_REQ;
            ST_REQ: begin
                // The in-flight request keeps its old address; its response is dropped later.
                if (redirect) begin
                    pc_n   = ra;
                    drop_n = 1'b1;
                end
                if (mem_req_ready) state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect) begin
                    pc_n = ra;
                    if (mem_rsp_valid) begin
                        drop_n  = 1'b0;
                        state_n = ST_REQ;
                    end else begin
                        drop_n = 1'b1;
                    end
                end else if (mem_rsp_valid) begin
                    if (drop) begin
                        drop_n  = 1'b0;
                        state_n = ST_REQ;
                    end else begin
                        load_out = 1'b1;
                        state_n  = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_n    = ra;
                    state_n = ST_REQ;
                end else if (out_ready) begin
                    if (mis_q) begin
                        state_n = ST_STALL;
                    end else begin
                        pc_n    = pc + XLEN'(4);
                        state_n = ST_REQ;
                    end
                end
            end
            ST_STALL: begin
                if (redirect) begin
                    pc_n    = ra;
                    state_n = ST_REQ;
                end
            end
            default: state_n = ST_IDLE;
        endcase
`ifdef IFU_MISALIGN_CHK_EN
        // A misaligned target is never fetched; it is reported downstream instead.
        if (state_n == ST_REQ && state != ST_REQ && pc_n[1:0] != 2'b00) begin
            state_n  = ST_HOLD;
            load_mis = 1'b1;
        end
`endif
    end

    always_comb begin
        req_addr_n = req_addr;
        if (state_n == ST_REQ && state != ST_REQ) req_addr_n = pc_n;
        mis_n = mis_q;
        if (load_mis)                mis_n = 1'b1;
        else if (load_out)           mis_n = 1'b0;
        else if (state_n != ST_HOLD) mis_n = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            drop     <= 1'b0;
            out_inst <= '0;
            out_pc   <= RESET_PC;
            out_err  <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            req_addr <= req_addr_n;
            drop     <= drop_n;
            mis_q    <= mis_n;
            if (load_out) begin
                out_inst <= mem_rsp_data;
                out_pc   <= pc;
                out_err  <= mem_rsp_err;
            end else if (load_mis) begin
                out_inst <= '0;
                out_pc   <= pc_n;
                out_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_ifu.sv
// Directed bench for ysyx_ifu: fetch sequencing, stalls, redirects, faults, wrap and mid-fetch reset.
module tb_ysyx_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] KEY    = 32'h1357_9BDF;
`ifdef IFU_MISALIGN_CHK_EN
    localparam logic [31:0] REQ_REDIR = 32'h8000_0300;
`else
    localparam logic [31:0] REQ_REDIR = 32'h8000_0303;
`endif

    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_err;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        misalign;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    ysyx_ifu dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_err(out_err), .redirect(redirect), .redirect_addr(redirect_addr),
        .misalign(misalign), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: the word returned is a fixed function of the address in flight.
    assign mem_rsp_data = mem_req_addr ^ KEY;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        out_ready     = 1'b0;
        redirect      = 1'b0;
        redirect_addr = '0;
    endtask

    // Scoreboard: every consumed instruction must match the next expected pc.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_consume: got pc=%h, required no consume", out_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (out_pc !== e) begin
                    errors++;
                    $display("FAIL sb_pc: got %h required %h", out_pc, e);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        tick();
        tick();
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b required 0", mem_req_valid); end
        checks++; if (mem_req_addr !== RST_PC) begin errors++; $display("FAIL rst_req_addr: got %h required %h", mem_req_addr, RST_PC); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL rst_out_inst: got %h required 0", out_inst); end
        checks++; if (out_pc !== RST_PC) begin errors++; $display("FAIL rst_out_pc: got %h required %h", out_pc, RST_PC); end
        checks++; if (out_err !== 1'b0 || misalign !== 1'b0) begin errors++; $display("FAIL rst_err_mis: got %b%b required 00", out_err, misalign); end
        rst = 1'b1;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_idle: got %b required 0", mem_req_valid); end
        tick();
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC) begin errors++; $display("FAIL rst_first_req: got %b/%h required 1/%h", mem_req_valid, mem_req_addr, RST_PC); end
    endtask

    task automatic test_seq();
        logic [31:0] p;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        out_ready     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            p = RST_PC + 32'(4 * i);
            exp_q.push_back(p);
            checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== p) begin errors++; $display("FAIL seq_req: got %b/%h required 1/%h", mem_req_valid, mem_req_addr, p); end
            tick();
            checks++; if (mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL seq_wait: got %b/%b required 0/0", mem_req_valid, out_valid); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== p || out_inst !== (p ^ KEY)) begin errors++; $display("FAIL seq_out: got %b/%h/%h required 1/%h/%h", out_valid, out_pc, out_inst, p, p ^ KEY); end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_rsp_err();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_err   = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_pc !== 32'h8000_0008) begin errors++; $display("FAIL err_out: got %b/%b/%h required 1/1/80000008", out_valid, out_err, out_pc); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0008 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL err_hold: got %b/%h/%b required 1/80000008/0", out_valid, out_pc, mem_req_valid); end
        exp_q.push_back(32'h8000_0008);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_000C) begin errors++; $display("FAIL err_next: got %b/%b/%h required 0/1/8000000c", out_valid, mem_req_valid, mem_req_addr); end
    endtask

    task automatic test_req_stall();
        for (int i = 0; i < 5; i++) begin
            checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_000C) begin errors++; $display("FAIL stall_hold: cycle %0d got %b/%h required 1/8000000c", i, mem_req_valid, mem_req_addr); end
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_single: got %b required 0", mem_req_valid); end
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_000C) begin errors++; $display("FAIL stall_out: got %b/%h required 1/8000000c", out_valid, out_pc); end
        exp_q.push_back(32'h8000_000C);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (mem_req_addr !== 32'h8000_0010) begin errors++; $display("FAIL stall_next: got %h required 80000010", mem_req_addr); end
    endtask

    task automatic test_redirect_wait();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        redirect      = 1'b1;
        redirect_addr = 32'h8000_0100;
        tick();
        redirect = 1'b0;
        checks++; if (mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rw_wait: got %b/%b required 0/0", mem_req_valid, out_valid); end
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0100) begin errors++; $display("FAIL rw_drop: got %b/%b/%h required 0/1/80000100", out_valid, mem_req_valid, mem_req_addr); end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0100 || out_inst !== (32'h8000_0100 ^ KEY)) begin errors++; $display("FAIL rw_out: got %b/%h/%h required 1/80000100/%h", out_valid, out_pc, out_inst, 32'h8000_0100 ^ KEY); end
        exp_q.push_back(32'h8000_0100);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_redirect_hold();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0104) begin errors++; $display("FAIL rh_out: got %b/%h required 1/80000104", out_valid, out_pc); end
        exp_q.push_back(32'h8000_0104);
        out_ready     = 1'b1;
        redirect      = 1'b1;
        redirect_addr = 32'h8000_0200;
        tick();
        drive_idle();
        checks++; if (out_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0200) begin errors++; $display("FAIL rh_next: got %b/%b/%h required 0/1/80000200", out_valid, mem_req_valid, mem_req_addr); end
    endtask

    task automatic test_redirect_req();
        mem_req_ready = 1'b1;
        redirect      = 1'b1;
        redirect_addr = REQ_REDIR;
        tick();
        drive_idle();
        checks++; if (mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rr_wait: got %b/%b required 0/0", mem_req_valid, out_valid); end
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0300) begin errors++; $display("FAIL rr_next: got %b/%b/%h required 0/1/80000300", out_valid, mem_req_valid, mem_req_addr); end
    endtask

    task automatic test_wrap();
        redirect      = 1'b1;
        redirect_addr = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0300) begin errors++; $display("FAIL wrap_inflight: got %b/%h required 1/80000300", mem_req_valid, mem_req_addr); end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || mem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_drop: got %b/%h required 0/fffffffc", out_valid, mem_req_addr); end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_out: got %b/%h required 1/fffffffc", out_valid, out_pc); end
        exp_q.push_back(32'hFFFF_FFFC);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr: got %b/%h required 1/00000000", mem_req_valid, mem_req_addr); end
    endtask

    task automatic test_reset_mid();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== RST_PC || out_pc !== RST_PC || out_valid !== 1'b0) begin errors++; $display("FAIL rm_clear: got %b/%h/%h/%b required 0/%h/%h/0", mem_req_valid, mem_req_addr, out_pc, out_valid, RST_PC, RST_PC); end
        tick();
        rst           = 1'b1;
        mem_rsp_valid = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC) begin errors++; $display("FAIL rm_late1: got %b/%b/%h required 0/1/%h", out_valid, mem_req_valid, mem_req_addr, RST_PC); end
        tick();
        mem_rsp_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || mem_req_valid !== 1'b1) begin errors++; $display("FAIL rm_late2: got %b/%b required 0/1", out_valid, mem_req_valid); end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== RST_PC || out_inst !== (RST_PC ^ KEY)) begin errors++; $display("FAIL rm_out: got %b/%h/%h required 1/%h/%h", out_valid, out_pc, out_inst, RST_PC, RST_PC ^ KEY); end
        exp_q.push_back(RST_PC);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (mem_req_addr !== 32'h8000_0004) begin errors++; $display("FAIL rm_next: got %h required 80000004", mem_req_addr); end
    endtask

`ifdef IFU_MISALIGN_CHK_EN
    task automatic test_misalign();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        redirect      = 1'b1;
        redirect_addr = 32'h8000_0102;
        tick();
        drive_idle();
        checks++; if (out_valid !== 1'b1 || misalign !== 1'b1 || out_pc !== 32'h8000_0102) begin errors++; $display("FAIL mis_out: got %b/%b/%h required 1/1/80000102", out_valid, misalign, out_pc); end
        checks++; if (out_inst !== 32'h0 || out_err !== 1'b0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_payload: got %h/%b/%b required 0/0/0", out_inst, out_err, mem_req_valid); end
        exp_q.push_back(32'h8000_0102);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || mem_req_valid !== 1'b0 || misalign !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b/%b/%b required 0/0/0", out_valid, mem_req_valid, misalign); end
        redirect      = 1'b1;
        redirect_addr = 32'h8000_0400;
        tick();
        redirect = 1'b0;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0400) begin errors++; $display("FAIL mis_resume: got %b/%h required 1/80000400", mem_req_valid, mem_req_addr); end
    endtask
`endif

    initial begin
        test_reset();
        test_seq();
        test_rsp_err();
        test_req_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_redirect_req();
        test_wrap();
        test_reset_mid();
`ifdef IFU_MISALIGN_CHK_EN
        test_misalign();
`endif
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
